// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD bridge-slot arbiters: slot state encoding,
// sector-buffer width derivation and the default timeout counter width.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int TOW_DEFAULT = 24;

  // Most-significant data bit of the sector buffer: 8-bit or 16-bit bridge.
  function automatic int buf_dw(input int wide);
    return (wide != 0) ? 15 : 7;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend scanning upward
// from ptr, wrapping at N.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = |pend;
    // Scan from the farthest candidate down so the closest to ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      logic [PW-1:0] jj;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (pend[jj]) idx = jj;
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares one SD virtual-drive slot of the HPS bridge among NREQ requesters:
// round-robin grant held for a whole sector, with per-requester done/timeout.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int WIDE = 0,
  parameter int TOW  = TOW_DEFAULT,
  localparam int DW  = buf_dw(WIDE),
  localparam int PW  = $clog2(NREQ)
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_rd,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [32*NREQ-1:0]     req_lba,
  input  logic [(DW+1)*NREQ-1:0] req_buff_din,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic [NREQ-1:0]        req_buff_wr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [DW:0]            sd_buff_din
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     lba_q, lba_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [TOW-1:0]  tmo_q, tmo_d;
  logic            err_q, err_d;

  logic [TOW-1:0]  tmo_inc;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic [31:0]     win_lba;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .pend  (req_rd | req_wr),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .valid (win_vld)
  );

  assign win_lba = req_lba[32*int'(win_idx) +: 32];
  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // A stray sd_ack here is ignored; only pending requests matter.
        if (win_vld) begin
          state_d = ST_ISSUE;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          lba_d   = win_lba;
          rd_d    = req_rd[win_idx];
          wr_d    = ~req_rd[win_idx] & req_wr[win_idx];
          ptr_d   = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end else if (&tmo_inc) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          tmo_d   = tmo_inc;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_XFER: begin
        if (!sd_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        grant_d = '0;
        err_d   = 1'b0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign grant    = grant_q;
  assign sd_lba   = lba_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign req_done = (state_q == ST_DONE && !err_q) ? grant_q : '0;
  assign req_err  = (state_q == ST_DONE &&  err_q) ? grant_q : '0;

  // Buffer routing stays combinational: the bridge samples sd_buff_din in the
  // same cycle it advances sd_buff_addr.
  assign req_buff_wr = grant_q & {NREQ{sd_buff_wr}};

  always_comb begin
    sd_buff_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) sd_buff_din = sd_buff_din | req_buff_din[i*(DW+1) +: DW+1];
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: directed requests push expected issue
// and completion records; a negedge monitor pops and compares them.
module tb_sd_req_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  req_rd = '0;
  logic [2:0]  req_wr = '0;
  logic [95:0] req_lba = '0;
  logic [23:0] req_buff_din = '0;
  logic [2:0]  grant, req_done, req_err, req_buff_wr;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [2:0]  g;
    logic [31:0] lba;
    logic        rd;
    logic        wr;
    int          len;
  } iss_t;

  typedef struct {
    logic [2:0] done;
    logic [2:0] err;
  } cmp_t;

  iss_t iss_q[$];
  cmp_t cmp_q[$];
  int   run_len = 0;
  int   cur_len = 0;

  sd_req_arbiter #(.NREQ(3), .WIDE(0), .TOW(4)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_buff_din (req_buff_din),
    .grant        (grant),
    .req_done     (req_done),
    .req_err      (req_err),
    .req_buff_wr  (req_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_iss(input logic [2:0] g, input logic [31:0] lba,
                          input logic rd, input logic wr, input int len);
    iss_t e;
    e.g = g; e.lba = lba; e.rd = rd; e.wr = wr; e.len = len;
    iss_q.push_back(e);
  endtask

  task automatic push_cmp(input logic [2:0] done, input logic [2:0] err);
    cmp_t c;
    c.done = done; c.err = err;
    cmp_q.push_back(c);
  endtask

  // Monitor: issue windows and completion pulses against the scoreboard.
  always @(negedge clk_sys) begin
    iss_t e;
    cmp_t c;
    if (sd_rd | sd_wr) begin
      if (run_len == 0) begin
        if (iss_q.size() == 0) chk("unexpected_issue", iss_q.size(), 1);
        else begin
          e = iss_q.pop_front();
          chk("iss_grant", 32'(grant), 32'(e.g));
          chk("iss_lba", sd_lba, e.lba);
          chk("iss_rd", 32'(sd_rd), 32'(e.rd));
          chk("iss_wr", 32'(sd_wr), 32'(e.wr));
          chk("iss_onehot", $countones(grant), 1);
          cur_len = e.len;
        end
      end
      run_len++;
    end else if (run_len != 0) begin
      chk("iss_len", run_len, cur_len);
      run_len = 0;
    end
    if ((req_done | req_err) != 3'b000) begin
      if (cmp_q.size() == 0) chk("unexpected_done", cmp_q.size(), 1);
      else begin
        c = cmp_q.pop_front();
        chk("done_vec", 32'(req_done), 32'(c.done));
        chk("err_vec", 32'(req_err), 32'(c.err));
        chk("grant_at_done", 32'(grant), 32'(c.done | c.err));
      end
    end
  end

  task automatic wait_issue(output bit ok);
    int t = 0;
    while (!(sd_rd | sd_wr) && t < 40) begin
      tick();
      t++;
    end
    ok = sd_rd | sd_wr;
    chk("issue_seen", 32'(ok), 32'd1);
  endtask

  // Bridge + requester model for one sector; releases the request on done/err.
  task automatic serve(input int dly, input int len, input bit no_ack,
                       input logic [2:0] exp_g, input logic [7:0] exp_din,
                       input logic [2:0] late_rd);
    bit ok;
    int t;
    logic [2:0] v;
    wait_issue(ok);
    if (!ok) return;
    req_rd = req_rd | late_rd;
    if (!no_ack) begin
      repeat (dly) tick();
      sd_ack = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick();
        sd_buff_wr = (i % 3) != 2;
        #1;
        if (i < 6) begin
          chk("buff_wr_route", 32'(req_buff_wr), sd_buff_wr ? 32'(exp_g) : 32'd0);
          chk("buff_din_route", 32'(sd_buff_din), 32'(exp_din));
        end
      end
      tick();
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
    end
    t = 0;
    while ((req_done | req_err) == 3'b000 && t < 40) begin
      tick();
      t++;
    end
    if (no_ack) chk("err_latency", t, 15);
    else chk("done_latency", t, 1);
    v = req_done | req_err;
    req_rd = req_rd & ~v;
    req_wr = req_wr & ~v;
    tick();
    chk("pulse_width", 32'(req_done | req_err), 32'd0);
  endtask

  initial begin
    bit ok;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_err", 32'(req_err), 0);

    // Contention: all three read from reset; req 0 re-asserts after its turn.
    req_lba = {32'h0000_0C02, 32'h0000_0B01, 32'h0000_0A00};
    req_buff_din = {8'h33, 8'h22, 8'h11};
    req_rd = 3'b111;
    push_iss(3'b001, 32'h0A00, 1'b1, 1'b0, 3); push_cmp(3'b001, 3'b000);
    push_iss(3'b010, 32'h0B01, 1'b1, 1'b0, 3); push_cmp(3'b010, 3'b000);
    push_iss(3'b100, 32'h0C02, 1'b1, 1'b0, 3); push_cmp(3'b100, 3'b000);
    push_iss(3'b001, 32'h0A00, 1'b1, 1'b0, 3); push_cmp(3'b001, 3'b000);
    repeat (2) tick();
    reset_n = 1'b1;
    serve(2, 8, 1'b0, 3'b001, 8'h11, 3'b000);
    req_rd[0] = 1'b1;
    serve(2, 8, 1'b0, 3'b010, 8'h22, 3'b000);
    serve(2, 8, 1'b0, 3'b100, 8'h33, 3'b000);
    serve(2, 8, 1'b0, 3'b001, 8'h11, 3'b000);

    // Single read of a full sector on requester 1.
    req_lba[63:32] = 32'h0000_1234;
    req_rd[1] = 1'b1;
    push_iss(3'b010, 32'h1234, 1'b1, 1'b0, 6); push_cmp(3'b010, 3'b000);
    serve(5, 512, 1'b0, 3'b010, 8'h22, 3'b000);

    // Write on requester 2: only its buffer slice reaches the bridge.
    req_buff_din = {8'hA5, 8'h00, 8'h00};
    req_lba[95:64] = 32'h0000_5678;
    req_wr[2] = 1'b1;
    push_iss(3'b100, 32'h5678, 1'b0, 1'b1, 4); push_cmp(3'b100, 3'b000);
    serve(3, 16, 1'b0, 3'b100, 8'hA5, 3'b000);

    // Read and write together on requester 0: read wins.
    req_lba[31:0] = 32'h0000_9ABC;
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    push_iss(3'b001, 32'h9ABC, 1'b1, 1'b0, 3); push_cmp(3'b001, 3'b000);
    serve(2, 8, 1'b0, 3'b001, 8'h00, 3'b000);

    // Timeout on requester 0 with TOW=4, then requester 1 is served.
    req_rd[0] = 1'b1;
    push_iss(3'b001, 32'h9ABC, 1'b1, 1'b0, 15); push_cmp(3'b000, 3'b001);
    push_iss(3'b010, 32'h1234, 1'b1, 1'b0, 3);  push_cmp(3'b010, 3'b000);
    serve(0, 0, 1'b1, 3'b001, 8'h00, 3'b010);
    serve(2, 8, 1'b0, 3'b010, 8'h00, 3'b000);

    // Reset in the middle of a transfer on requester 2.
    req_lba[95:64] = 32'h0000_0077;
    req_rd[2] = 1'b1;
    push_iss(3'b100, 32'h0077, 1'b1, 1'b0, 3);
    wait_issue(ok);
    repeat (2) tick();
    sd_ack = 1'b1;
    repeat (4) tick();
    sd_buff_wr = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_sd_rd", 32'(sd_rd), 0);
    chk("mid_rst_sd_wr", 32'(sd_wr), 0);
    chk("mid_rst_sd_lba", sd_lba, 0);
    chk("mid_rst_done", 32'(req_done), 0);
    chk("mid_rst_err", 32'(req_err), 0);
    chk("mid_rst_buff_wr", 32'(req_buff_wr), 0);
    chk("mid_rst_buff_din", 32'(sd_buff_din), 0);
    req_rd = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    req_lba[63:32] = 32'h0000_0099;
    req_rd[1] = 1'b1;
    push_iss(3'b010, 32'h0099, 1'b1, 1'b0, 3); push_cmp(3'b010, 3'b000);
    serve(2, 8, 1'b0, 3'b010, 8'h00, 3'b000);

    repeat (5) tick();
    chk("iss_q_drained", iss_q.size(), 0);
    chk("cmp_q_drained", cmp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares one SD block-access virtual-drive slot of the HPS I/O bridge (sd_lba/sd_rd/sd_wr/sd_ack plus sector buffer) among NREQ core-side requesters, e.g. floppy, tape and hard-disk emulations.
- Arbitrates round-robin and drives exactly one of sd_rd/sd_wr at a time.
- Holds the grant for the whole sector transfer and routes sector-buffer traffic to the granted requester only.
- Reports per-requester completion or timeout.

Parameters:
NREQ, 3, number of requesters (2..8)
WIDE, 0, 0 = 8-bit sector buffer (DW=7), 1 = 16-bit (DW=15); must match the bridge
TOW, 24, timeout counter width; ISSUE abandons after 2^TOW-1 cycles without sd_ack

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
req_rd  in  NREQ  level read request per requester; held until req_done/req_err
req_wr  in  NREQ  level write request per requester; held until req_done/req_err
req_lba  in  32*NREQ  sector LBA; slice i belongs to requester i; stable while requesting
req_buff_din  in  (DW+1)*NREQ  per-requester write data for the buffer address on sd_buff_addr
grant  out  NREQ  one-hot; requester currently owning the slot; 0 when idle
req_done  out  NREQ  1-cycle pulse; transfer completed
req_err  out  NREQ  1-cycle pulse; timeout, no transfer
req_buff_wr  out  NREQ  sd_buff_wr routed to the granted requester only
sd_lba  out  32  to bridge
sd_rd  out  1  to bridge
sd_wr  out  1  to bridge
sd_ack  in  1  from bridge; high for the duration of the sector transfer
sd_buff_wr  in  1  from bridge
sd_buff_din  out  DW+1  to bridge; muxed req_buff_din of the granted requester, 0 when idle

Behaviour:
- Reset (async assert, sync release): state IDLE; grant, req_done, req_err, sd_rd, sd_wr and sd_lba are 0; RR pointer 0; timeout counter 0. Reset mid-transfer abandons it silently; no done/err is issued.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - Pending vector is req_rd|req_wr.
  - Winner is the first set bit scanning from ptr upward, wrapping at NREQ.
  - On a winner, registers the following and goes to ISSUE, so sd_rd/sd_wr rise 1 cycle after the request is sampled:
    - grant <= onehot(winner)
    - sd_lba <= req_lba slice of winner
    - sd_rd <= req_rd[w]
    - sd_wr <= ~req_rd[w] & req_wr[w] (read wins if both set)
    - ptr <= winner+1 mod NREQ
  - sd_ack high in IDLE is stray and ignored.
- ISSUE:
  - Holds sd_rd/sd_wr and increments the timeout counter.
  - sd_ack==1 → clear sd_rd/sd_wr and go to XFER.
  - Counter reaches all-ones → clear sd_rd/sd_wr, set the err flag, go to DONE.
  - Requester deasserting its request during ISSUE is ignored; the request is latched.
- XFER:
  - sd_ack==0 → go to DONE.
  - No timeout; the bridge always completes.
- DONE, one cycle:
  - req_done[g] (or req_err[g] if err flag set) is high for exactly this cycle.
  - Next cycle: grant <= 0, err flag and counter cleared, state IDLE.
  - Requesters deassert on seeing done/err, so the next IDLE does not re-grant a finished request.
- Buffer routing is combinational:
  - req_buff_wr = grant & {NREQ{sd_buff_wr}}.
  - sd_buff_din = OR over i of (grant[i] ? slice i : 0).
  - No extra latency, because the bridge samples sd_buff_din in the same cycle it advances sd_buff_addr.
- Fairness: with all requesters pending continuously, grant order is 0,1,…,NREQ-1,0,…
- Invariants:
  - At most one grant bit set.
  - sd_rd and sd_wr are never both 1.
  - sd_rd|sd_wr only in ISSUE.

Decomposition:
- Shared package sd_arb_pkg holds:
  - state encoding enum (IDLE=0, ISSUE=1, XFER=2, DONE=3)
  - DW derivation function from WIDE
  - default TOW constant
- Sub-module rr_pick (combinational round-robin priority picker: inputs pending vector and ptr; outputs winner index and valid). It is reused by other bridge-slot arbiters.

Test Plan:
- Single read: req_rd[1]=1, lba=0x0000_1234; bridge raises sd_ack 5 cycles later for 512 cycles → sd_rd high from cycle+1 until the cycle after ack, sd_lba=0x1234, grant=3'b010, req_buff_wr mirrors sd_buff_wr, one req_done[1] pulse 1 cycle after ack falls.
- Contention: all three requesters request reads from reset → grants in order 0,1,2 with no overlap; a continuously re-asserted req 0 is next granted only after 1 and 2.
- Write routing: req_wr[2]=1 with req_buff_din slice 2 = 0xA5, others 0x00 → sd_wr=1, sd_rd=0, sd_buff_din=0xA5 during XFER.
- Read+write same requester: req_rd[0]=req_wr[0]=1 → only sd_rd asserted.
- Timeout: TOW=4, no sd_ack → sd_rd drops after 15 cycles in ISSUE, single req_err[0] pulse, no req_done, arbiter returns to IDLE and serves req 1 next.
- Reset mid-XFER: reset_n low while sd_ack=1 → all outputs 0 immediately, no done/err pulse; after release, a new request issues normally.
